// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Purpose: the datapath-wide word type, plus the IF/ID pipeline latch record
//          and the bubble constant used by the fetch stage.
// Contents:
//   word_t      - 32-bit datapath word
//   NOP_INSTR   - encoding of the bubble instruction (sll $0,$0,0)
//   ifid_t      - IF/ID latch contents {instr, pcplus4, valid}
//   IFID_BUBBLE - latch value that represents "no instruction"
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam word_t NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      word_t instr;
      word_t pcplus4;
      logic  valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
// Purpose: bundles the fetch stage's cache, hazard, redirect and IF/ID signals.
// Modports:
//   fs - used by the fetch stage itself
//   tb - used by a bench or a surrounding datapath that drives the stage
// Signals:
//   ihit, imemload           - instruction cache response
//   imemREN, imemaddr        - instruction cache request
//   stall, dstall            - hazard-unit interlock / data-memory freeze
//   flush, npc_redirect      - taken branch/jump redirect
//   halt                     - HALT reached memory stage
//   instr_dec, pcplus4_dec,
//   valid_dec                - IF/ID latch contents seen by decode
//   fetch_count              - instructions accepted into IF/ID
interface fetch_stage_if;
   import cpu_types_pkg::*;

   logic  ihit;
   word_t imemload;
   logic  imemREN;
   word_t imemaddr;
   logic  stall;
   logic  dstall;
   logic  flush;
   word_t npc_redirect;
   logic  halt;
   word_t instr_dec;
   word_t pcplus4_dec;
   logic  valid_dec;
   logic [31:0] fetch_count;

   modport fs (
      input  ihit, imemload, stall, dstall, flush, npc_redirect, halt,
      output imemREN, imemaddr, instr_dec, pcplus4_dec, valid_dec, fetch_count
   );

   modport tb (
      output ihit, imemload, stall, dstall, flush, npc_redirect, halt,
      input  imemREN, imemaddr, instr_dec, pcplus4_dec, valid_dec, fetch_count
   );

endinterface

// File: rtl/fetch_stage_ifid_latch.sv
// ifid_latch
// Purpose: IF/ID pipeline register with hold / bubble / load controls.
// Ports:
//   CLK, nRST   - clock and asynchronous active-low reset (resets to bubble)
//   hold_i      - keep the current contents (highest priority)
//   bubble_i    - replace contents with a bubble
//   load_i      - capture load_data_i
//   load_data_i - new latch contents
//   ifid_o      - current latch contents
module ifid_latch
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  hold_i,
   input  logic  bubble_i,
   input  logic  load_i,
   input  ifid_t load_data_i,
   output ifid_t ifid_o
);

   ifid_t ifid_q;
   ifid_t ifid_d;

   always_comb begin
      ifid_d = ifid_q;
      if (hold_i) begin
         ifid_d = ifid_q;
      end else if (bubble_i) begin
         ifid_d = IFID_BUBBLE;
      end else if (load_i) begin
         ifid_d = load_data_i;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ifid_q <= IFID_BUBBLE;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign ifid_o = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Purpose: instruction-fetch stage. Holds the PC, issues instruction-cache
//          reads, tracks the sticky halted state, counts accepted
//          instructions and steers the IF/ID latch feeding decode.
// Parameters:
//   PCINIT - PC value loaded on reset
// Ports:
//   CLK  - system clock, rising edge
//   nRST - asynchronous active-low reset
//   fsif - fetch_stage_if.fs bundle (cache, hazard, redirect, IF/ID, count)
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter word_t PCINIT = 32'h0000_0000
)(
   input logic        CLK,
   input logic        nRST,
   fetch_stage_if.fs  fsif
);

   word_t       pc_q, pc_d;
   logic        halted_q, halted_d;
   logic [31:0] count_q, count_d;
   word_t       pcplus4;

   logic  ifidHold;
   logic  ifidBubble;
   logic  ifidLoad;
   ifid_t ifidNext;
   ifid_t ifidCur;

   // Modular add; low PC bits pass through untouched.
   assign pcplus4 = pc_q + 32'd4;

   // Next-state selection. Order matters: a data-side freeze beats
   // everything, halt beats a redirect, and a redirect kills whatever
   // decode holds even when the hazard unit is stalling it.
   always_comb begin
      pc_d       = pc_q;
      halted_d   = halted_q;
      count_d    = count_q;
      ifidHold   = 1'b0;
      ifidBubble = 1'b0;
      ifidLoad   = 1'b0;
      if (fsif.dstall) begin
         ifidHold = 1'b1;
      end else if (halted_q || fsif.halt) begin
         halted_d   = 1'b1;
         ifidBubble = 1'b1;
      end else if (fsif.flush) begin
         pc_d       = fsif.npc_redirect;
         ifidBubble = 1'b1;
      end else if (fsif.stall) begin
         ifidHold = 1'b1;
      end else if (fsif.ihit) begin
         pc_d     = pcplus4;
         count_d  = count_q + 32'd1;
         ifidLoad = 1'b1;
      end else begin
         ifidBubble = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pc_q     <= PCINIT;
         halted_q <= 1'b0;
         count_q  <= 32'd0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
         count_q  <= count_d;
      end
   end

   assign ifidNext = '{instr: fsif.imemload, pcplus4: pcplus4, valid: 1'b1};

   ifid_latch u_ifid (
      .CLK         (CLK),
      .nRST        (nRST),
      .hold_i      (ifidHold),
      .bubble_i    (ifidBubble),
      .load_i      (ifidLoad),
      .load_data_i (ifidNext),
      .ifid_o      (ifidCur)
   );

   assign fsif.imemaddr    = pc_q;
   assign fsif.imemREN     = ~halted_q;
   assign fsif.instr_dec   = ifidCur.instr;
   assign fsif.pcplus4_dec = ifidCur.pcplus4;
   assign fsif.valid_dec   = ifidCur.valid;
   assign fsif.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Purpose: directed bench for fetch_stage. A behavioural model of the stage
// is advanced on each rising edge and compared with the DUT on every falling
// edge; directed scenarios add literal expectations at key points.
module tb_fetch_stage;

   localparam logic [31:0] PCINIT = 32'h0000_0000;

   logic CLK;
   logic nRST;
   int   checks;
   int   errors;
   bit   checkEn;

   fetch_stage_if fsif ();

   fetch_stage #(.PCINIT(PCINIT)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .fsif (fsif)
   );

   // 10-unit clock period
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Behavioural model state
   logic [31:0] mPc;
   logic        mHalted;
   logic [31:0] mCount;
   logic [31:0] mInstr;
   logic [31:0] mPc4;
   logic        mValid;

   // Model: apply the prioritised per-cycle rules directly
   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         mPc = PCINIT; mHalted = 1'b0; mCount = 0;
         mInstr = 0; mPc4 = 0; mValid = 1'b0;
      end else if (fsif.dstall) begin
         // frozen
      end else if (mHalted || fsif.halt) begin
         mHalted = 1'b1;
         mInstr = 0; mPc4 = 0; mValid = 1'b0;
      end else if (fsif.flush) begin
         mPc = fsif.npc_redirect;
         mInstr = 0; mPc4 = 0; mValid = 1'b0;
      end else if (fsif.stall) begin
         // decode keeps its instruction, PC waits
      end else if (fsif.ihit) begin
         mInstr = fsif.imemload;
         mPc4   = mPc + 32'd4;
         mValid = 1'b1;
         mPc    = mPc + 32'd4;
         mCount = mCount + 1;
      end else begin
         mInstr = 0; mPc4 = 0; mValid = 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model comparison on every falling edge once the bench has started
   always @(negedge CLK) begin
      if (checkEn) begin
         checkOutput("model_imemaddr", fsif.imemaddr, mPc);
         checkOutput("model_imemREN", {31'b0, fsif.imemREN}, {31'b0, ~mHalted});
         checkOutput("model_instr_dec", fsif.instr_dec, mInstr);
         checkOutput("model_pcplus4_dec", fsif.pcplus4_dec, mPc4);
         checkOutput("model_valid_dec", {31'b0, fsif.valid_dec}, {31'b0, mValid});
         checkOutput("model_fetch_count", fsif.fetch_count, mCount);
      end
   end

   // Drive one cycle's inputs, then wait for the following falling edge
   task automatic applyStimulus(input logic ihit, input logic [31:0] load,
                                input logic stall, input logic dstall,
                                input logic flush, input logic [31:0] npc,
                                input logic halt);
      fsif.ihit = ihit;
      fsif.imemload = load;
      fsif.stall = stall;
      fsif.dstall = dstall;
      fsif.flush = flush;
      fsif.npc_redirect = npc;
      fsif.halt = halt;
      @(negedge CLK);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      checkEn = 1'b0;
      nRST = 1'b1;
      fsif.ihit = 0; fsif.imemload = 0; fsif.stall = 0; fsif.dstall = 0;
      fsif.flush = 0; fsif.npc_redirect = 0; fsif.halt = 0;
      #2 nRST = 1'b0;
      checkEn = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      checkOutput("reset_imemaddr", fsif.imemaddr, 32'h0);
      checkOutput("reset_imemREN", {31'b0, fsif.imemREN}, 32'h1);
      checkOutput("reset_valid", {31'b0, fsif.valid_dec}, 32'h0);
      checkOutput("reset_count", fsif.fetch_count, 32'h0);
      nRST = 1'b1;

      // Sequential fetch with hits every cycle
      applyStimulus(1, 32'h2001_0005, 0, 0, 0, 0, 0);
      checkOutput("seq_instr", fsif.instr_dec, 32'h2001_0005);
      checkOutput("seq_pc4_first", fsif.pcplus4_dec, 32'h4);
      checkOutput("seq_valid", {31'b0, fsif.valid_dec}, 32'h1);
      applyStimulus(1, 32'h2001_0005, 0, 0, 0, 0, 0);
      checkOutput("seq_pc4_second", fsif.pcplus4_dec, 32'h8);
      applyStimulus(1, 32'h2001_0005, 0, 0, 0, 0, 0);
      checkOutput("seq_count3", fsif.fetch_count, 32'd3);
      checkOutput("seq_addr", fsif.imemaddr, 32'hC);

      // Cache miss for three cycles at 0x40
      applyStimulus(0, 0, 0, 0, 1, 32'h40, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
         checkOutput("miss_addr", fsif.imemaddr, 32'h40);
         checkOutput("miss_valid", {31'b0, fsif.valid_dec}, 32'h0);
         checkOutput("miss_ren", {31'b0, fsif.imemREN}, 32'h1);
      end
      applyStimulus(1, 32'h0000_0020, 0, 0, 0, 0, 0);
      checkOutput("miss_done_pc4", fsif.pcplus4_dec, 32'h44);
      checkOutput("miss_done_count", fsif.fetch_count, 32'd4);

      // Load-use stall holds decode and PC
      applyStimulus(1, 32'h8C22_0000, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 32'h1111_1111, 1, 0, 0, 0, 0);
         checkOutput("stall_instr", fsif.instr_dec, 32'h8C22_0000);
         checkOutput("stall_addr", fsif.imemaddr, 32'h48);
      end
      applyStimulus(1, 32'h0000_0011, 0, 0, 0, 0, 0);
      checkOutput("unstall_instr", fsif.instr_dec, 32'h0000_0011);
      checkOutput("unstall_pc4", fsif.pcplus4_dec, 32'h4C);
      checkOutput("unstall_count", fsif.fetch_count, 32'd6);

      // Redirect wins over stall; dstall freezes a redirect
      applyStimulus(0, 0, 1, 0, 1, 32'h100, 0);
      checkOutput("flush_addr", fsif.imemaddr, 32'h100);
      checkOutput("flush_valid", {31'b0, fsif.valid_dec}, 32'h0);
      applyStimulus(1, 32'h0000_0077, 0, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_0099, 0, 1, 1, 32'h200, 0);
      checkOutput("dstall_addr", fsif.imemaddr, 32'h104);
      checkOutput("dstall_instr", fsif.instr_dec, 32'h0000_0077);
      checkOutput("dstall_count", fsif.fetch_count, 32'd7);

      // Halt at 0x20, later redirect ignored
      applyStimulus(0, 0, 0, 0, 1, 32'h20, 0);
      applyStimulus(1, 32'h0000_0055, 0, 0, 0, 0, 1);
      checkOutput("halt_ren", {31'b0, fsif.imemREN}, 32'h0);
      checkOutput("halt_addr", fsif.imemaddr, 32'h20);
      checkOutput("halt_valid", {31'b0, fsif.valid_dec}, 32'h0);
      applyStimulus(1, 32'h0000_0055, 0, 0, 1, 32'h300, 0);
      checkOutput("halt_flush_ignored", fsif.imemaddr, 32'h20);
      checkOutput("halt_sticky", {31'b0, fsif.imemREN}, 32'h0);

      // Asynchronous reset away from a clock edge
      #2 nRST = 1'b0;
      #1;
      checkOutput("async_rst_addr", fsif.imemaddr, PCINIT);
      checkOutput("async_rst_ren", {31'b0, fsif.imemREN}, 32'h1);
      @(negedge CLK);
      nRST = 1'b1;

      // PC wrap past the top of memory
      applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      applyStimulus(1, 32'h0000_0005, 0, 0, 0, 0, 0);
      checkOutput("wrap_pc4", fsif.pcplus4_dec, 32'h0);
      checkOutput("wrap_addr", fsif.imemaddr, 32'h0);
      checkOutput("wrap_valid", {31'b0, fsif.valid_dec}, 32'h1);

      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkEn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined datapath: holds the PC, drives the instruction-cache request, and owns the IF/ID pipeline latch that feeds decode. It consumes `stall` from the hazard unit (load-use interlock on the decode-stage instruction), a memory-freeze from the data side, and branch/jump redirects from later stages. It sits between the instruction cache and decode.

## Interface
Parameters:
- PCINIT, 32'h0000_0000, PC value loaded on reset

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction cache has valid data for `imemaddr` this cycle
- imemload  in  32 (word_t)  instruction returned by the cache
- imemREN  out  1  instruction read request
- imemaddr  out  32 (word_t)  fetch address (= current PC)
- stall  in  1  hazard-unit interlock: hold IF/ID and PC
- dstall  in  1  data-memory access pending: freeze entire stage
- flush  in  1  taken branch/jump resolved downstream
- npc_redirect  in  32 (word_t)  redirect target, valid with `flush`
- halt  in  1  HALT reached memory stage; stop fetching
- instr_dec  out  32 (word_t)  IF/ID instruction
- pcplus4_dec  out  32 (word_t)  IF/ID PC+4
- valid_dec  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_count  out  32  number of instructions accepted into IF/ID

## Operation
- `imemaddr = pc`; `imemREN = !halted` (combinational).
- Per-cycle action, first matching rule wins:
  1. dstall=1: hold PC, IF/ID, halted, fetch_count.
  2. halted=1 or halt=1: set halted; hold PC; IF/ID <= bubble. A flush in the same cycle is ignored.
  3. flush=1: PC <= npc_redirect; IF/ID <= bubble (regardless of ihit/stall; wrong-path instruction in decode is killed).
  4. stall=1: hold PC and IF/ID.
  5. ihit=1: PC <= PC+4; IF/ID <= {imemload, PC+4, valid=1}; fetch_count += 1.
  6. ihit=0: hold PC; IF/ID <= bubble.
- Bubble = instr 32'h0 (sll $0 nop), pcplus4 32'h0, valid 0.
- PC+4 is 32-bit modular: 32'hFFFF_FFFC + 4 = 32'h0. No alignment check; low two PC bits are carried through.
- fetch_count wraps mod 2^32.
- halted is sticky; cleared only by nRST.

## Timing
- Reset (async, nRST low): pc=PCINIT, instr_dec=0, pcplus4_dec=0, valid_dec=0, halted=0, fetch_count=0; hence imemREN=1, imemaddr=PCINIT.
- Latency: instruction returned with ihit in cycle N appears on instr_dec/valid_dec after the CLK edge ending cycle N.
- Redirect: flush in cycle N → imemaddr=npc_redirect in cycle N+1; valid_dec=0 in N+1.
- Halt: halt in cycle N → imemREN=0 from N+1 onward; IF/ID drains to bubbles.
- A miss (ihit low for k cycles) keeps imemaddr and imemREN constant for those k cycles and produces k bubbles (unless stall/dstall).
- Reset mid-miss: outstanding request abandoned; fetch restarts at PCINIT.

## Structure
- word_t from cpu_types_pkg; add `ifid_t` packed struct {word_t instr; word_t pcplus4; logic valid;} and constant `NOP_INSTR = 32'h0` to cpu_types_pkg.
- Ports bundled in `fetch_stage_if.vh` with modports `fs` (block) and `tb` (bench), mirroring the other pipeline-stage interfaces.
- One sub-module: `ifid_latch` (ifid_t register with hold/bubble/load controls, async reset to bubble); PC, halted and counter logic stay in `fetch_stage`.

## Test plan
- Reset, PCINIT=0, ihit=1 every cycle, imemload=0x2001_0005 → imemaddr 0,4,8,…; instr_dec=0x2001_0005, pcplus4_dec=4 then 8; valid_dec=1 from first edge; fetch_count=3 after 3 cycles.
- ihit low 3 cycles at pc=0x40 → imemaddr held 0x40, imemREN=1, three bubbles (valid_dec=0); then ihit → pcplus4_dec=0x44, fetch_count +1.
- stall=1 for 2 cycles with instr_dec=0x8C22_0000 → instr_dec, valid_dec, imemaddr unchanged; release → advance normally.
- flush with npc_redirect=0x100 while stall=1 and ihit=0 → next cycle imemaddr=0x100, valid_dec=0; dstall=1 with flush → nothing changes.
- halt asserted at pc=0x20 → imemREN=0 next cycle, PC frozen, valid_dec=0; later flush ignored; nRST low → pc=PCINIT, imemREN=1.
- PC wrap: flush to 0xFFFF_FFFC, ihit=1 → pcplus4_dec=0, next imemaddr=0.
